// File: rtl/smoldvi_x5_sequencer.sv
// clk_x5-side sequencer for the TMDS serialiser: recovers symbol framing from
// the pix-domain toggle, drives the 5-phase slice index, load strobe and pad enable.
module smoldvi_x5_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 16,
  parameter int LOAD_OFFSET = 2,
  parameter int SLIP_W      = 8
) (
  input  logic              clk_x5,
  input  logic              rst_n_x5,
  input  logic              en,
  input  logic              pix_toggle,
  output logic [2:0]        phase,
  output logic              load,
  output logic              out_en,
  output logic              locked,
  output logic              slip_pulse,
  output logic [SLIP_W-1:0] slip_count
);

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACQUIRE,
    S_TRACK,
    S_RUN
  } state_t;

  state_t              state_q, state_d;
  logic [SYNC_STAGES-1:0] tog_sync_q, en_sync_q;
  logic                tog_s_q;
  logic [2:0]          phase_q, phase_d;
  logic [GOOD_W-1:0]   good_q, good_d, good_inc;
  logic                load_q, load_d;
  logic                run_q;
  logic                slip_pulse_q, slip_pulse_d;
  logic [SLIP_W-1:0]   slip_count_q, slip_count_d;
  logic                tog_s, en_s, tog_edge, at_4, mismatch;

  assign tog_s    = tog_sync_q[SYNC_STAGES-1];
  assign en_s     = en_sync_q[SYNC_STAGES-1];
  assign tog_edge = tog_s ^ tog_s_q;
  assign at_4     = (phase_q == 3'd4);
  assign mismatch = tog_edge ^ at_4;
  assign good_inc = good_q + 1'b1;

  always_ff @(posedge clk_x5 or negedge rst_n_x5) begin
    if (!rst_n_x5) begin
      tog_sync_q   <= '0;
      en_sync_q    <= '0;
      tog_s_q      <= 1'b0;
      state_q      <= S_IDLE;
      phase_q      <= '0;
      good_q       <= '0;
      load_q       <= 1'b0;
      run_q        <= 1'b0;
      slip_pulse_q <= 1'b0;
      slip_count_q <= '0;
    end else begin
      tog_sync_q   <= {tog_sync_q[SYNC_STAGES-2:0], pix_toggle};
      en_sync_q    <= {en_sync_q[SYNC_STAGES-2:0], en};
      tog_s_q      <= tog_s;
      state_q      <= state_d;
      phase_q      <= phase_d;
      good_q       <= good_d;
      load_q       <= load_d;
      run_q        <= (state_d == S_RUN);
      slip_pulse_q <= slip_pulse_d;
      slip_count_q <= slip_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = at_4 ? 3'd0 : phase_q + 3'd1;
    good_d       = good_q;
    slip_pulse_d = 1'b0;
    slip_count_d = slip_count_q;

    unique case (state_q)
      S_IDLE: begin
        phase_d = '0;
        good_d  = '0;
        if (en_s) state_d = S_ACQUIRE;
      end
      S_ACQUIRE: begin
        if (tog_edge) begin
          phase_d = '0;
          good_d  = '0;
          state_d = S_TRACK;
        end
      end
      S_TRACK: begin
        if (tog_edge && at_4) begin
          good_d = good_inc;
          if (good_inc == GOOD_W'(LOCK_COUNT)) state_d = S_RUN;
        end else if (tog_edge) begin
          phase_d = '0;
          good_d  = '0;
        end else if (at_4) begin
          good_d = '0;
        end
      end
      S_RUN: begin
        if (mismatch) begin
          slip_pulse_d = 1'b1;
          if (slip_count_q != '1) slip_count_d = slip_count_q + 1'b1;
          state_d = S_TRACK;
          good_d  = '0;
          if (tog_edge) phase_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Disable overrides everything, including a slip detected in the same cycle.
    if (!en_s) begin
      state_d      = S_IDLE;
      phase_d      = '0;
      good_d       = '0;
      slip_pulse_d = 1'b0;
      slip_count_d = slip_count_q;
    end

    load_d = (phase_d == 3'(LOAD_OFFSET)) && ((state_d == S_TRACK) || (state_d == S_RUN));
  end

  assign phase      = phase_q;
  assign load       = load_q;
  assign out_en     = run_q;
  assign locked     = run_q;
  assign slip_pulse = slip_pulse_q;
  assign slip_count = slip_count_q;

endmodule

// File: tb/tb_smoldvi_x5_sequencer.sv
// Directed bench for smoldvi_x5_sequencer: lock, long/short period slips,
// slip counter saturation (SLIP_W=2 instance), enable drop and async reset.
module tb_smoldvi_x5_sequencer;

  logic       clk_x5 = 1'b0;
  logic       rst_n_x5;
  logic       en;
  logic       pix_toggle;
  logic [2:0] phase, phase2;
  logic       load, out_en, locked, slip_pulse;
  logic       load2, out_en2, locked2, slip_pulse2;
  logic [7:0] slip_count;
  logic [1:0] slip_count2;

  int checks = 0;
  int errors = 0;
  int pulses2 = 0;

  always #5 clk_x5 = ~clk_x5;

  smoldvi_x5_sequencer dut (
    .clk_x5(clk_x5), .rst_n_x5(rst_n_x5), .en(en), .pix_toggle(pix_toggle),
    .phase(phase), .load(load), .out_en(out_en), .locked(locked),
    .slip_pulse(slip_pulse), .slip_count(slip_count)
  );

  smoldvi_x5_sequencer #(.SLIP_W(2)) dut_sat (
    .clk_x5(clk_x5), .rst_n_x5(rst_n_x5), .en(en), .pix_toggle(pix_toggle),
    .phase(phase2), .load(load2), .out_en(out_en2), .locked(locked2),
    .slip_pulse(slip_pulse2), .slip_count(slip_count2)
  );

  always @(negedge clk_x5)
    if (rst_n_x5 && slip_pulse2) pulses2++;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk_x5);
  endtask

  task automatic flip();
    pix_toggle = ~pix_toggle;
  endtask

  task automatic run_periods(input int k);
    repeat (k) begin
      flip();
      wait_n(5);
    end
  endtask

  // Final (LOCK_COUNT-th) good edge: lock rises exactly 3 clocks after the flip.
  task automatic lock_tail(input string tag);
    flip();
    wait_n(2);
    chk({tag, "_pre_lock"}, int'(locked), 0);
    wait_n(1);
    chk({tag, "_locked"}, int'(locked), 1);
    chk({tag, "_out_en"}, int'(out_en), 1);
    chk({tag, "_phase0"}, int'(phase), 0);
    wait_n(2);
  endtask

  task automatic short_slip_relock(input string tag);
    flip();
    wait_n(4);
    flip();
    wait_n(2);
    chk({tag, "_still_locked"}, int'(locked), 1);
    wait_n(1);
    chk({tag, "_slip_pulse"}, int'(slip_pulse), 1);
    chk({tag, "_phase_realign"}, int'(phase), 0);
    chk({tag, "_out_en_drop"}, int'(out_en), 0);
    wait_n(2);
    run_periods(15);
    lock_tail(tag);
  endtask

  initial begin
    rst_n_x5   = 1'b0;
    en         = 1'b0;
    pix_toggle = 1'b0;
    wait_n(2);
    chk("rst_phase", int'(phase), 0);
    chk("rst_load", int'(load), 0);
    chk("rst_out_en", int'(out_en), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_slip_pulse", int'(slip_pulse), 0);
    chk("rst_slip_count", int'(slip_count), 0);
    rst_n_x5 = 1'b1;

    // Test 1: lock
    en = 1'b1;
    wait_n(10);
    chk("acq_load", int'(load), 0);
    chk("acq_locked", int'(locked), 0);
    run_periods(16);
    lock_tail("t1");
    chk("t1_slip_count", int'(slip_count), 0);
    flip();
    for (int i = 0; i < 5; i++) begin
      chk("t1_phase_seq", int'(phase), (2 + i) % 5);
      chk("t1_load_seq", int'(load), (i == 0) ? 1 : 0);
      wait_n(1);
    end

    // Test 2: one 6-cycle period
    flip();
    wait_n(6);
    flip();
    wait_n(1);
    chk("t2_still_locked", int'(locked), 1);
    wait_n(1);
    chk("t2_slip_pulse", int'(slip_pulse), 1);
    chk("t2_slip_count", int'(slip_count), 1);
    chk("t2_out_en", int'(out_en), 0);
    chk("t2_locked", int'(locked), 0);
    wait_n(1);
    chk("t2_pulse_end", int'(slip_pulse), 0);
    chk("t2_phase_realign", int'(phase), 0);
    wait_n(2);
    run_periods(15);
    lock_tail("t2");

    // Test 3: one 4-cycle period
    short_slip_relock("t3");
    chk("t3_slip_count", int'(slip_count), 2);
    chk("t3_sat_count", int'(slip_count2), 2);

    // Test 4: three more slips saturate the 2-bit counter
    short_slip_relock("t4a");
    chk("t4_sat_count_3", int'(slip_count2), 3);
    short_slip_relock("t4b");
    short_slip_relock("t4c");
    chk("t4_sat_hold", int'(slip_count2), 3);
    chk("t4_sat_pulses", pulses2, 5);
    chk("t4_main_count", int'(slip_count), 5);

    // Test 5: drop en in RUN while the expected edge is also missing
    en = 1'b0;
    wait_n(2);
    chk("t5_locked_before", int'(locked), 1);
    wait_n(1);
    chk("t5_locked", int'(locked), 0);
    chk("t5_out_en", int'(out_en), 0);
    chk("t5_phase", int'(phase), 0);
    chk("t5_load", int'(load), 0);
    chk("t5_no_slip", int'(slip_pulse), 0);
    chk("t5_count_kept", int'(slip_count), 5);
    wait_n(5);
    chk("t5_idle_phase", int'(phase), 0);
    chk("t5_idle_load", int'(load), 0);
    en = 1'b1;
    wait_n(10);
    run_periods(16);
    lock_tail("t5");
    chk("t5_count_after", int'(slip_count), 5);

    // Test 6: async reset mid-RUN
    run_periods(2);
    #2 rst_n_x5 = 1'b0;
    #1;
    chk("t6_phase", int'(phase), 0);
    chk("t6_load", int'(load), 0);
    chk("t6_out_en", int'(out_en), 0);
    chk("t6_locked", int'(locked), 0);
    chk("t6_slip_pulse", int'(slip_pulse), 0);
    chk("t6_slip_count", int'(slip_count), 0);
    chk("t6_sat_count", int'(slip_count2), 0);
    wait_n(2);
    rst_n_x5 = 1'b1;
    wait_n(10);
    chk("t6_relock_pending", int'(locked), 0);
    run_periods(16);
    lock_tail("t6");
    chk("t6_count_final", int'(slip_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
